// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the synchronous SRAM responder.
// Used by sram_responder and sram_responder_mem.
package sram_responder_pkg;

    localparam int DATA_W     = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE
    } state_e;

    function automatic logic [DATA_W-1:0] lane_mask(
        input logic              lb,
        input logic              ub,
        input logic [DATA_W-1:0] w
    );
        lane_mask = {ub ? w[15:8] : 8'h00, lb ? w[7:0] : 8'h00};
    endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// Single-port 16-bit RAM with byte-lane writes and a registered,
// write-first read port. Contents are never reset.
import sram_responder_pkg::*;

module sram_responder_mem #(
    parameter int AW = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [1:0]        be_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            if (be_i[0]) rdata_d[7:0]  = wdata_i[7:0];
            if (be_i[1]) rdata_d[15:8] = wdata_i[15:8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i && be_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
        if (we_i && be_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Synchronous SRAM target model with configurable read latency.
// Define SRAM_RESPONDER_STATS_EN to add rd_count/wr_count outputs.
import sram_responder_pkg::*;

module sram_responder #(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              sram_ce_n,
    input  logic              sram_we_n,
    input  logic              sram_oe_n,
    input  logic              sram_lb_n,
    input  logic              sram_ub_n,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
`ifdef SRAM_RESPONDER_STATS_EN
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
`endif
    output logic              err_conflict
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sram_responder: RD_LAT out of range");
    end
    if (MEM_AW > ADDR_W) begin : g_bad_aw
        $error("sram_responder: MEM_AW exceeds ADDR_W");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              lb_q, lb_d;
    logic              ub_q, ub_d;
    logic              err_q, err_d;
    logic              rd_start;

    logic              sel;
    logic              wr;
    logic              rd_req;
    logic              conflict;
    logic [MEM_AW-1:0] word;
    logic [DATA_W-1:0] rdata;

    assign word     = sram_addr[MEM_AW-1:0];
    assign sel      = !sram_ce_n && (!sram_lb_n || !sram_ub_n);
    assign wr       = sel && !sram_we_n;
    assign rd_req   = sel && !sram_oe_n && sram_we_n;
    assign conflict = !sram_ce_n && !sram_we_n && !sram_oe_n;

    // Upper address bits alias onto the storage; they are deliberately dropped.
    if (MEM_AW < ADDR_W) begin : g_alias
        logic unused_hi;
        assign unused_hi = ^sram_addr[ADDR_W-1:MEM_AW];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        lb_d     = lb_q;
        ub_d     = ub_q;
        err_d    = err_q | conflict;
        rd_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d  = RD_WAIT;
                    cnt_d    = LAT_LOAD;
                    addr_d   = word;
                    lb_d     = !sram_lb_n;
                    ub_d     = !sram_ub_n;
                    rd_start = 1'b1;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (wr || !rd_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (word != addr_q) begin
                    state_d  = RD_WAIT;
                    cnt_d    = LAT_LOAD;
                    addr_d   = word;
                    lb_d     = !sram_lb_n;
                    ub_d     = !sram_ub_n;
                    rd_start = 1'b1;
                end else begin
                    lb_d = !sram_lb_n;
                    ub_d = !sram_ub_n;
                    if (state_q == RD_WAIT) begin
                        if (cnt_q == '0) state_d = RD_DRIVE;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lb_q    <= 1'b0;
            ub_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lb_q    <= lb_d;
            ub_q    <= ub_d;
            err_q   <= err_d;
        end
    end

    // Read port follows the next latched address so data is ready on entry to RD_DRIVE.
    sram_responder_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (wr),
        .be_i    ({!sram_ub_n, !sram_lb_n}),
        .waddr_i (word),
        .wdata_i (sram_dq_in),
        .raddr_i (addr_d),
        .rdata_o (rdata)
    );

    assign sram_dq_oe   = (state_q == RD_DRIVE);
    assign sram_dq_out  = sram_dq_oe ? lane_mask(lb_q, ub_q, rdata) : '0;
    assign err_conflict = err_q;

`ifdef SRAM_RESPONDER_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_start && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
        if (wr && wr_cnt_q != '1)       wr_cnt_d = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
